// File: rtl/cordic_seq_ctrl.sv
// Iterative CORDIC rotation sequencer: one micro-rotation per clock, indexes external atan table.
// Latency: out_valid rises exactly ITER clocks after the input accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module cordic_seq_ctrl #(
  parameter int ITER   = 23,
  parameter int XY_W   = 24,
  parameter int K_INIT = 2547004
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [24:0]     angle_in,
  output logic        [5:0]      atan_index,
  input  logic        [22:0]     atan_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [XY_W-1:0] cos_out,
  output logic signed [XY_W-1:0] sin_out,
  output logic                   range_err,
  output logic                   busy
);

  localparam int ZW = 25;
  localparam int IW = 5;
  localparam logic signed [ZW-1:0] ANG_POS = 25'sd8388608;
  localparam logic signed [ZW-1:0] ANG_NEG = -25'sd8388608;
  localparam logic [IW-1:0] LAST_ITER = IW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic signed [XY_W-1:0] x_q, x_d;
  logic signed [XY_W-1:0] y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d;
  logic signed [XY_W-1:0] cos_q, cos_d;
  logic signed [XY_W-1:0] sin_q, sin_d;
  logic                   out_valid_q, out_valid_d;
  logic                   range_err_q, range_err_d;

  logic signed [ZW-1:0]   angle_clamped;
  logic                   clamp_hit;
  logic signed [XY_W-1:0] x_sh, y_sh, x_nx, y_nx;
  logic signed [ZW-1:0]   z_nx, atan_ext;

  // Clamp the requested angle into the +/-90 degree range and flag when that happened
  always_comb begin
    angle_clamped = angle_in;
    clamp_hit     = 1'b0;
    if (angle_in > ANG_POS) begin
      angle_clamped = ANG_POS;
      clamp_hit     = 1'b1;
    end else if (angle_in < ANG_NEG) begin
      angle_clamped = ANG_NEG;
      clamp_hit     = 1'b1;
    end
  end

  // One micro-rotation: steer towards z=0, all three terms taken from the old x/y/z
  always_comb begin
    x_sh     = x_q >>> iter_q;
    y_sh     = y_q >>> iter_q;
    atan_ext = $signed({2'b00, atan_val});
    if (!z_q[ZW-1]) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_ext;
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_ext;
    end
  end

  // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    out_valid_d = out_valid_q;
    range_err_d = range_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d     = S_RUN;
          iter_d      = '0;
          x_d         = XY_W'(K_INIT);
          y_d         = '0;
          z_d         = angle_clamped;
          range_err_d = clamp_hit;
        end
      end
      S_RUN: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        if (iter_q == LAST_ITER) begin
          // Final rotation lands straight in the result registers
          state_d     = S_DONE;
          iter_d      = '0;
          cos_d       = x_nx;
          sin_d       = y_nx;
          out_valid_d = 1'b1;
        end else begin
          iter_d = iter_q + 5'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; any conversion in flight is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      iter_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      out_valid_q <= out_valid_d;
      range_err_q <= range_err_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign atan_index = (state_q == S_RUN) ? {1'b0, iter_q} : 6'd0;
  assign out_valid  = out_valid_q;
  assign cos_out    = cos_q;
  assign sin_out    = sin_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: fixed vectors, stall/reset/back-to-back
// sequences, and randomized angles checked against trig of the clamped angle.
module tb_cordic_seq_ctrl;

  localparam int  ITER = 23;
  localparam int  TOL  = 64;
  localparam real PI   = 3.14159265358979323846;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [24:0] angle_in;
  logic        [5:0]  atan_index;
  logic        [22:0] atan_val;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] cos_out;
  logic signed [23:0] sin_out;
  logic               range_err;
  logic               busy;

  logic [22:0] atan_tab [0:63];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int angle;
    int exp_cos;
    int exp_sin;
    int exp_err;
  } vec_t;

  vec_t vecs [8];

  cordic_seq_ctrl #(.ITER(ITER), .XY_W(24), .K_INIT(2547004)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .angle_in   (angle_in),
    .atan_index (atan_index),
    .atan_val   (atan_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cos_out    (cos_out),
    .sin_out    (sin_out),
    .range_err  (range_err),
    .busy       (busy)
  );

  // External arctangent table, combinational lookup
  assign atan_val = atan_tab[atan_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp_v, input int tol);
    int diff;
    checks++;
    diff = (act > exp_v) ? act - exp_v : exp_v - act;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp_v, tol);
    end
  endtask

  // Reference: exact trig of the clamped angle, scaled to 2^22
  function automatic void ref_model(input int ang, output int ec, output int es, output int eerr);
    int  c;
    real rad;
    c    = ang;
    eerr = 0;
    if (c > 8388608) begin
      c    = 8388608;
      eerr = 1;
    end else if (c < -8388608) begin
      c    = -8388608;
      eerr = 1;
    end
    rad = real'(c) * PI / 16777216.0;
    ec  = int'($cos(rad) * 4194304.0);
    es  = int'($sin(rad) * 4194304.0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request/response transaction with optional DONE stall of `hold` cycles
  task automatic run_conv(input string nm, input int ang, input int ec, input int es,
                          input int eerr, input int hold, input bit chk_idx);
    int c0, s0;
    for (int w = 0; w < 100 && !in_ready; w++) tick();
    chk($sformatf("%s_in_ready", nm), int'(in_ready), 1, 0);
    angle_in  = 25'(ang);
    in_valid  = 1'b1;
    out_ready = 1'($urandom);
    tick();
    for (int k = 0; k < ITER; k++) begin
      if (chk_idx) chk($sformatf("%s_atan_index_%0d", nm, k), int'(atan_index), k, 0);
      if (k == 0 || k == ITER - 1) begin
        chk($sformatf("%s_run_out_valid_%0d", nm, k), int'(out_valid), 0, 0);
        chk($sformatf("%s_run_in_ready_%0d", nm, k), int'(in_ready), 0, 0);
        chk($sformatf("%s_run_busy_%0d", nm, k), int'(busy), 1, 0);
      end
      in_valid  = 1'($urandom);
      angle_in  = 25'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    chk($sformatf("%s_out_valid", nm), int'(out_valid), 1, 0);
    chk($sformatf("%s_done_in_ready", nm), int'(in_ready), 0, 0);
    chk($sformatf("%s_done_atan_index", nm), int'(atan_index), 0, 0);
    chk($sformatf("%s_cos", nm), int'(cos_out), ec, TOL);
    chk($sformatf("%s_sin", nm), int'(sin_out), es, TOL);
    chk($sformatf("%s_range_err", nm), int'(range_err), eerr, 0);
    if (hold > 0) begin
      out_ready = 1'b0;
      c0 = int'(cos_out);
      s0 = int'(sin_out);
      for (int k = 0; k < hold; k++) begin
        in_valid = (k % 2 == 0);
        angle_in = 25'($urandom);
        tick();
        chk($sformatf("%s_hold_out_valid_%0d", nm, k), int'(out_valid), 1, 0);
        chk($sformatf("%s_hold_cos_%0d", nm, k), int'(cos_out), c0, 0);
        chk($sformatf("%s_hold_sin_%0d", nm, k), int'(sin_out), s0, 0);
        chk($sformatf("%s_hold_in_ready_%0d", nm, k), int'(in_ready), 0, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk($sformatf("%s_post_out_valid", nm), int'(out_valid), 0, 0);
    chk($sformatf("%s_post_in_ready", nm), int'(in_ready), 1, 0);
    chk($sformatf("%s_post_busy", nm), int'(busy), 0, 0);
    chk($sformatf("%s_post_cos", nm), int'(cos_out), ec, TOL);
  endtask

  initial begin
    int ec, es, eerr, ang, hold, first, second;

    for (int i = 0; i < 64; i++)
      atan_tab[i] = 23'(int'($atan(2.0 ** (-i)) * 16777216.0 / PI));

    vecs[0] = '{angle: 0,        exp_cos: 4194304, exp_sin: 0,        exp_err: 0};
    vecs[1] = '{angle: 4194304,  exp_cos: 2965821, exp_sin: 2965821,  exp_err: 0};
    vecs[2] = '{angle: -8388608, exp_cos: 0,       exp_sin: -4194304, exp_err: 0};
    vecs[3] = '{angle: 9000000,  exp_cos: 0,       exp_sin: 4194304,  exp_err: 1};
    vecs[4] = '{angle: 8388608,  exp_cos: 0,       exp_sin: 4194304,  exp_err: 0};
    vecs[5] = '{angle: -9000000, exp_cos: 0,       exp_sin: -4194304, exp_err: 1};
    vecs[6] = '{angle: -4194304, exp_cos: 2965821, exp_sin: -2965821, exp_err: 0};
    vecs[7] = '{angle: 8388609,  exp_cos: 0,       exp_sin: 4194304,  exp_err: 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    angle_in  = '0;
    repeat (3) tick();

    chk("reset_in_ready", int'(in_ready), 1, 0);
    chk("reset_out_valid", int'(out_valid), 0, 0);
    chk("reset_busy", int'(busy), 0, 0);
    chk("reset_atan_index", int'(atan_index), 0, 0);
    chk("reset_cos", int'(cos_out), 0, 0);
    chk("reset_sin", int'(sin_out), 0, 0);
    chk("reset_range_err", int'(range_err), 0, 0);

    rst_n = 1'b1;
    tick();

    // Fixed vectors
    for (int i = 0; i < 8; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].angle, vecs[i].exp_cos, vecs[i].exp_sin,
               vecs[i].exp_err, 0, (i == 0));

    // DONE stall with ignored in_valid pulses, then a normal follow-up request
    run_conv("stall", 4194304, 2965821, 2965821, 0, 10, 1'b0);
    run_conv("after_stall", -8388608, 0, -4194304, 0, 0, 1'b0);
    run_conv("pre_reset", 4194304, 2965821, 2965821, 0, 0, 1'b0);

    // Reset during iteration 10
    angle_in = 25'(3000000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("midrun_atan_index", int'(atan_index), 10, 0);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    chk("midrst_in_ready", int'(in_ready), 1, 0);
    chk("midrst_atan_index", int'(atan_index), 0, 0);
    chk("midrst_busy", int'(busy), 0, 0);
    chk("midrst_cos", int'(cos_out), 0, 0);
    rst_n = 1'b1;
    ref_model(-3000000, ec, es, eerr);
    run_conv("after_reset", -3000000, ec, es, eerr, 0, 1'b1);

    // Back-to-back spacing with in_valid and out_ready held high
    angle_in  = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    first     = -1;
    second    = -1;
    for (int c = 0; c < 200; c++) begin
      if (in_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      tick();
      if (second >= 0) break;
    end
    in_valid = 1'b0;
    for (int w = 0; w < 100 && busy; w++) tick();
    out_ready = 1'b0;
    chk("b2b_spacing", second - first, ITER + 2, 0);
    chk("b2b_drained_busy", int'(busy), 0, 0);
    chk("b2b_cos", int'(cos_out), 4194304, TOL);
    chk("b2b_sin", int'(sin_out), 0, TOL);

    // Randomized angles, including out-of-range ones, with random stalls
    for (int r = 0; r < 25; r++) begin
      ang  = int'($urandom_range(19000000)) - 9500000;
      hold = int'($urandom_range(3));
      ref_model(ang, ec, es, eerr);
      run_conv($sformatf("rnd%0d_a%0d", r, ang), ang, ec, es, eerr, hold, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
